// File: rtl/reg_bank_reader.sv
// Read-side controller for the lab register bank: snapshots one entry (or a wrapping
// burst over all entries) and presents each word on a valid/ready handshake.
module reg_bank_reader #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH*DEPTH-1:0] regs,
  input  logic                   rd_req,
  input  logic [AW-1:0]          rd_addr,
  input  logic                   burst,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [AW-1:0]          out_addr,
  output logic                   out_last
);

  typedef enum logic [1:0] {StIdle, StFetch, StPresent} state_e;

  state_e           r_state;
  logic [AW-1:0]    r_cur_addr;
  logic [AW-1:0]    r_remaining;
  logic             r_busy;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [AW-1:0]    r_addr;
  logic             r_last;
  logic [WIDTH-1:0] w_word;

  assign w_word = regs[WIDTH*int'(r_cur_addr) +: WIDTH];

  // All outputs are registered; the bank is only sampled on the FETCH edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_addr      <= '0;
      r_last      <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (rd_req) begin
            r_cur_addr  <= rd_addr;
            r_remaining <= burst ? AW'(DEPTH - 1) : '0;
            r_busy      <= 1'b1;
            r_state     <= StFetch;
          end
        end
        StFetch: begin
          r_data  <= w_word;
          r_addr  <= r_cur_addr;
          r_last  <= (r_remaining == '0);
          r_valid <= 1'b1;
          r_state <= StPresent;
        end
        StPresent: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            if (r_remaining == '0) begin
              r_busy  <= 1'b0;
              r_state <= StIdle;
            end else begin
              r_cur_addr  <= r_cur_addr + AW'(1);
              r_remaining <= r_remaining - AW'(1);
              r_state     <= StFetch;
            end
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_addr  = r_addr;
  assign out_last  = r_last;

endmodule

// File: tb/tb_reg_bank_reader.sv
// Directed self-checking bench for reg_bank_reader (WIDTH=4, DEPTH=4).
module tb_reg_bank_reader;

  logic        clk;
  logic        rst;
  logic [15:0] regs;
  logic        rd_req;
  logic [1:0]  rd_addr;
  logic        burst;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_data;
  logic [1:0]  out_addr;
  logic        out_last;

  int n_tests;
  int n_fail;

  reg_bank_reader #(
    .WIDTH(4),
    .DEPTH(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .regs     (regs),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .burst    (burst),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_addr (out_addr),
    .out_last (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are sampled and inputs driven here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      regs      = 16'($urandom);
      rd_req    = 1'($urandom);
      rd_addr   = 2'($urandom);
      burst     = 1'($urandom);
      out_ready = 1'($urandom);
      step();
    end
    rst = 1'b0; rd_req = 1'b0; regs = 16'hA5C3; out_ready = 1'b1;
    n_tests++;
    if ({busy, out_valid, out_data, out_addr, out_last} !== 9'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b valid=%b data=%h addr=%h last=%b required all 0",
               busy, out_valid, out_data, out_addr, out_last);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++;
      if ({busy, out_valid} !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_idle_%0d: got busy=%b valid=%b required 0 0", i, busy, out_valid);
      end
    end
  endtask

  task automatic test_single();
    regs = 16'hA5C3; rd_req = 1'b1; rd_addr = 2'd2; burst = 1'b0; out_ready = 1'b1;
    step();
    rd_req = 1'b0;
    n_tests++;
    if ({busy, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL single_fetch: got busy=%b valid=%b required 1 0", busy, out_valid);
    end
    step();
    n_tests++;
    if ({out_valid, out_data, out_addr, out_last} !== {1'b1, 4'h5, 2'd2, 1'b1}) begin
      n_fail++;
      $display("FAIL single_word: got valid=%b data=%h addr=%0d last=%b required 1 5 2 1",
               out_valid, out_data, out_addr, out_last);
    end
    step();
    n_tests++;
    if ({busy, out_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL single_done: got busy=%b valid=%b required 0 0", busy, out_valid);
    end
  endtask

  task automatic test_burst();
    logic [1:0] exp_addr [4] = '{2'd3, 2'd0, 2'd1, 2'd2};
    logic [3:0] exp_data [4] = '{4'hA, 4'h3, 4'hC, 4'h5};
    int words = 0;
    regs = 16'hA5C3; rd_req = 1'b1; rd_addr = 2'd3; burst = 1'b1; out_ready = 1'b1;
    step();
    rd_req = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (out_valid) begin
        if (words < 4) begin
          n_tests++;
          if ({out_addr, out_data, out_last} !==
              {exp_addr[words], exp_data[words], (words == 3)}) begin
            n_fail++;
            $display("FAIL burst_word_%0d: got addr=%0d data=%h last=%b required %0d %h %b",
                     words, out_addr, out_data, out_last, exp_addr[words], exp_data[words],
                     (words == 3));
          end
        end
        words++;
      end
    end
    n_tests++;
    if (words != 4 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL burst_count: got words=%0d busy=%b required 4 0", words, busy);
    end
  endtask

  task automatic test_backpressure();
    regs = 16'hA5C3; rd_req = 1'b1; rd_addr = 2'd1; burst = 1'b0; out_ready = 1'b0;
    step();
    rd_req = 1'b0;
    step();
    n_tests++;
    if ({out_valid, out_data} !== {1'b1, 4'hC}) begin
      n_fail++;
      $display("FAIL bp_first: got valid=%b data=%h required 1 c", out_valid, out_data);
    end
    regs = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      step();
      n_tests++;
      if ({out_valid, out_data, out_addr} !== {1'b1, 4'hC, 2'd1}) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: got valid=%b data=%h addr=%0d required 1 c 1",
                 i, out_valid, out_data, out_addr);
      end
    end
    out_ready = 1'b1;
    step();
    regs = 16'hA5C3;
    n_tests++;
    if ({busy, out_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL bp_release: got busy=%b valid=%b required 0 0", busy, out_valid);
    end
  endtask

  task automatic test_ignored();
    int words = 0;
    regs = 16'hA5C3; rd_req = 1'b1; rd_addr = 2'd3; burst = 1'b0; out_ready = 1'b1;
    step();
    // Keep requesting addr 0 through FETCH and the final handshake edge.
    rd_addr = 2'd0;
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ign_busy: got busy=%b required 1", busy);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 1) rd_req = 1'b0;
      if (out_valid) begin
        if (words == 0) begin
          n_tests++;
          if ({out_addr, out_data, out_last} !== {2'd3, 4'hA, 1'b1}) begin
            n_fail++;
            $display("FAIL ign_word: got addr=%0d data=%h last=%b required 3 a 1",
                     out_addr, out_data, out_last);
          end
        end
        words++;
      end
    end
    n_tests++;
    if (words != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ign_count: got words=%0d busy=%b required 1 0", words, busy);
    end
  endtask

  task automatic test_reset_mid_burst();
    regs = 16'hA5C3; rd_req = 1'b1; rd_addr = 2'd0; burst = 1'b1; out_ready = 1'b1;
    step();
    rd_req = 1'b0;
    step();
    step();
    step();
    n_tests++;
    if ({out_valid, out_addr, out_data} !== {1'b1, 2'd1, 4'hC}) begin
      n_fail++;
      $display("FAIL mid_second_word: got valid=%b addr=%0d data=%h required 1 1 c",
               out_valid, out_addr, out_data);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_tests++;
    if ({busy, out_valid, out_data, out_addr, out_last} !== 9'h0) begin
      n_fail++;
      $display("FAIL mid_reset: got busy=%b valid=%b data=%h addr=%h last=%b required all 0",
               busy, out_valid, out_data, out_addr, out_last);
    end
    rd_req = 1'b1; rd_addr = 2'd0; burst = 1'b0;
    step();
    rd_req = 1'b0;
    step();
    n_tests++;
    if ({out_valid, out_data, out_addr, out_last} !== {1'b1, 4'h3, 2'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_fresh_read: got valid=%b data=%h addr=%0d last=%b required 1 3 0 1",
               out_valid, out_data, out_addr, out_last);
    end
    step();
    n_tests++;
    if ({busy, out_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_fresh_done: got busy=%b valid=%b required 0 0", busy, out_valid);
    end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    regs      = 16'h0;
    rd_req    = 1'b0;
    rd_addr   = 2'd0;
    burst     = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_ignored();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
